rvfi_imem_track_check: RTL and testbench

- Multi-address, multi-channel instruction-memory consistency checker on the RVFI trace.
- Tracks NADDR halfword addresses. On the first fetch at each address it learns the 16-bit value. Every later retired fetch covering that address must return the same halfword.
- Optionally forgets a learned value when a retired store overwrites it, so self-modifying code does not raise false errors.
- Sits beside the core in formal and simulation benches. The formal wrapper drives trk_addr from constant free variables; a simulation bench drives it directly.

---
 rtl/rvfi_imem_track_check.sv | 120 ++++++++++++
 tb/tb_rvfi_imem_track_check.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_imem_track_check.sv
// Learns the first halfword fetched at each tracked address and flags any later retired fetch that disagrees.
// Latency 1 (registered outputs); passive observer, no backpressure.
module rvfi_imem_track_check #(
   parameter int XLEN         = 32,
   parameter int NRET         = 1,
   parameter int NADDR        = 2,
   parameter int INV_ON_STORE = 1,
   parameter int CNTW         = 16,
   parameter int IDXW         = 1
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [NADDR*XLEN-1:0]  i_trk_addr,
   input  logic [NRET-1:0]        i_rvfi_valid,
   input  logic [NRET*32-1:0]     i_rvfi_insn,
   input  logic [NRET*XLEN-1:0]   i_rvfi_pc_rdata,
   input  logic [NRET*XLEN-1:0]   i_rvfi_mem_addr,
   input  logic [NRET*XLEN/8-1:0] i_rvfi_mem_wmask,
   output logic [NADDR-1:0]       o_learned,
   output logic                   o_err,
   output logic [IDXW-1:0]        o_err_idx,
   output logic [CNTW-1:0]        o_check_count
);
   localparam int MB = XLEN / 8;

   logic [NADDR-1:0] r_learned;
   logic [15:0]      r_shadow [NADDR];
   logic             r_err;
   logic [IDXW-1:0]  r_err_idx;
   logic [CNTW-1:0]  r_cnt;

   logic [NADDR-1:0] w_learned;
   logic [15:0]      w_shadow [NADDR];
   logic             w_err;
   logic [IDXW-1:0]  w_err_idx;
   logic [CNTW-1:0]  w_cnt;
   logic [XLEN-1:0]  w_pc;
   logic [31:0]      w_insn;
   logic [XLEN-1:0]  w_a;
   logic [XLEN-1:0]  w_baddr;
   logic             w_hit;
   logic [15:0]      w_obs;

   // Channels chain in ascending order: each sees the state left by the one below it.
   always_comb begin
      w_learned = r_learned;
      w_shadow  = r_shadow;
      w_err     = r_err;
      w_err_idx = r_err_idx;
      w_cnt     = r_cnt;
      w_pc      = '0;
      w_insn    = '0;
      w_a       = '0;
      w_baddr   = '0;
      w_hit     = 1'b0;
      w_obs     = '0;
      for (int c = 0; c < NRET; c++) begin
         if (i_rvfi_valid[c]) begin
            w_pc   = i_rvfi_pc_rdata[c*XLEN +: XLEN];
            w_insn = i_rvfi_insn[c*32 +: 32];
            for (int i = 0; i < NADDR; i++) begin
               w_a   = i_trk_addr[i*XLEN +: XLEN] & ~XLEN'(1);
               w_hit = 1'b0;
               w_obs = w_insn[15:0];
               if (w_pc == w_a) begin
                  w_hit = 1'b1;
               end else if (w_insn[1:0] == 2'b11 && w_pc + XLEN'(2) == w_a) begin
                  w_hit = 1'b1;
                  w_obs = w_insn[31:16];
               end
               if (w_hit) begin
                  if (!w_learned[i]) begin
                     w_learned[i] = 1'b1;
                     w_shadow[i]  = w_obs;
                  end else begin
                     if (w_cnt != '1) w_cnt = w_cnt + CNTW'(1);
                     if (w_shadow[i] != w_obs && !w_err) begin
                        w_err     = 1'b1;
                        w_err_idx = IDXW'(i);
                     end
                  end
               end
            end
            // A store touching either byte of a tracked halfword forces a relearn.
            if (INV_ON_STORE != 0) begin
               for (int k = 0; k < MB; k++) begin
                  if (i_rvfi_mem_wmask[c*MB + k]) begin
                     w_baddr = i_rvfi_mem_addr[c*XLEN +: XLEN] + XLEN'(k);
                     for (int i = 0; i < NADDR; i++) begin
                        w_a = i_trk_addr[i*XLEN +: XLEN] & ~XLEN'(1);
                        if ((w_baddr & ~XLEN'(1)) == w_a) w_learned[i] = 1'b0;
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_learned <= '0;
         for (int i = 0; i < NADDR; i++) r_shadow[i] <= '0;
         r_err     <= 1'b0;
         r_err_idx <= '0;
         r_cnt     <= '0;
      end else begin
         r_learned <= w_learned;
         r_shadow  <= w_shadow;
         r_err     <= w_err;
         r_err_idx <= w_err_idx;
         r_cnt     <= w_cnt;
      end
   end

   assign o_learned     = r_learned;
   assign o_err         = r_err;
   assign o_err_idx     = r_err_idx;
   assign o_check_count = r_cnt;
endmodule

// File: tb/tb_rvfi_imem_track_check.sv
// Randomized and directed bench for rvfi_imem_track_check against a halfword-level reference model.
module tb_rvfi_imem_track_check;
   localparam int XLEN = 32;
   localparam int NRET = 2;
   localparam int NADDR = 4;
   localparam int CNTW = 6;
   localparam int IDXW = 2;
   localparam int MB = XLEN / 8;
   localparam int CMAX = (1 << CNTW) - 1;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic [XLEN-1:0]        trk [NADDR];
   logic [NADDR*XLEN-1:0]  trk_flat;
   logic [NRET-1:0]        valid;
   logic [NRET*32-1:0]     insn;
   logic [NRET*XLEN-1:0]   pc;
   logic [NRET*XLEN-1:0]   maddr;
   logic [NRET*MB-1:0]     wmask;
   logic [NADDR-1:0]       o_learned;
   logic                   o_err;
   logic [IDXW-1:0]        o_err_idx;
   logic [CNTW-1:0]        o_check_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   always_comb begin
      trk_flat = '0;
      for (int i = 0; i < NADDR; i++) trk_flat[i*XLEN +: XLEN] = trk[i];
   end

   rvfi_imem_track_check #(.XLEN(XLEN), .NRET(NRET), .NADDR(NADDR), .INV_ON_STORE(1),
                           .CNTW(CNTW), .IDXW(IDXW)) dut (
      .i_clk(clk), .i_reset(reset), .i_trk_addr(trk_flat), .i_rvfi_valid(valid),
      .i_rvfi_insn(insn), .i_rvfi_pc_rdata(pc), .i_rvfi_mem_addr(maddr),
      .i_rvfi_mem_wmask(wmask), .o_learned(o_learned), .o_err(o_err),
      .o_err_idx(o_err_idx), .o_check_count(o_check_count));

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a fetch delivers a list of (halfword address, value) pairs,
   // a store delivers a set of byte addresses; entries match on halfword identity.
   logic [NADDR-1:0] m_learned;
   logic [15:0]      m_val [NADDR];
   logic             m_err;
   int               m_idx;
   int               m_cnt;
   logic [XLEN-1:0]  h_addr [2];
   logic [15:0]      h_val [2];
   int               nh;
   logic [31:0]      m_w;
   logic [XLEN-1:0]  m_pc;
   logic [XLEN-1:0]  m_b;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_learned = '0;
         for (int i = 0; i < NADDR; i++) m_val[i] = '0;
         m_err = 1'b0;
         m_idx = 0;
         m_cnt = 0;
      end else begin
         for (int c = 0; c < NRET; c++) begin
            if (valid[c]) begin
               m_pc = pc[c*XLEN +: XLEN];
               m_w  = insn[c*32 +: 32];
               nh = 0;
               if (m_pc[0] == 1'b0) begin
                  h_addr[0] = m_pc; h_val[0] = m_w[15:0]; nh = 1;
                  if (m_w[1:0] == 2'b11) begin
                     h_addr[1] = m_pc + 32'd2; h_val[1] = m_w[31:16]; nh = 2;
                  end
               end
               for (int i = 0; i < NADDR; i++) begin
                  for (int h = 0; h < nh; h++) begin
                     if ((h_addr[h] >> 1) == (trk[i] >> 1)) begin
                        if (!m_learned[i]) begin
                           m_learned[i] = 1'b1;
                           m_val[i] = h_val[h];
                        end else begin
                           m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
                           if (m_val[i] != h_val[h] && !m_err) begin
                              m_err = 1'b1;
                              m_idx = i;
                           end
                        end
                     end
                  end
               end
               for (int k = 0; k < MB; k++) begin
                  if (wmask[c*MB + k]) begin
                     m_b = maddr[c*XLEN +: XLEN] + 32'(k);
                     for (int i = 0; i < NADDR; i++)
                        if ((m_b >> 1) == (trk[i] >> 1)) m_learned[i] = 1'b0;
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("learned", longint'(o_learned), longint'(m_learned));
         chk("err", longint'(o_err), longint'(m_err));
         chk("err_idx", longint'(o_err_idx), longint'(m_idx));
         chk("check_count", longint'(o_check_count), longint'(m_cnt));
      end
   end

   task automatic idle();
      valid = '0; insn = '0; pc = '0; maddr = '0; wmask = '0;
   endtask

   task automatic drive(input int c, input logic [31:0] p, input logic [31:0] w,
                        input logic [31:0] ma, input logic [3:0] wm);
      valid[c] = 1'b1;
      pc[c*XLEN +: XLEN] = p;
      insn[c*32 +: 32] = w;
      maddr[c*XLEN +: XLEN] = ma;
      wmask[c*MB +: MB] = wm;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      idle();
   endtask

   task automatic do_reset(input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3);
      idle();
      reset = 1'b1;
      trk[0] = a0; trk[1] = a1; trk[2] = a2; trk[3] = a3;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [15:0] memh(input logic [31:0] a);
      logic [31:0] t;
      t = a * 32'h9E37 ^ 32'h1357;
      return t[15:0];
   endfunction

   logic [31:0] apool [6] = '{32'h100, 32'h102, 32'h104, 32'h106, 32'h0, 32'h101};
   logic [31:0] ppool [7] = '{32'h100, 32'h102, 32'h104, 32'h101, 32'hFFFF_FFFE, 32'h0, 32'h106};
   logic [31:0] spool [4] = '{32'h100, 32'h104, 32'h0, 32'hFFFF_FFFC};

   initial begin
      logic [31:0] p;
      logic [15:0] lo;
      logic [15:0] hi;
      idle();
      do_reset(32'h100, 32'h102, 32'h400, 32'h400);
      chk("reset_learned", longint'(o_learned), 0);
      chk("reset_count", longint'(o_check_count), 0);

      drive(0, 32'h100, 32'h00A00093, 32'h0, 4'h0); step();
      chk("t1_learned", longint'(o_learned), 4'b0011);
      chk("t1_count0", longint'(o_check_count), 0);
      drive(0, 32'h100, 32'h00A00093, 32'h0, 4'h0); step();
      chk("t1_count2", longint'(o_check_count), 2);
      chk("t1_err", longint'(o_err), 0);

      do_reset(32'h100, 32'h102, 32'h400, 32'h400);
      drive(0, 32'h100, 32'h00A00093, 32'h0, 4'h0); step();
      drive(0, 32'h100, 32'h00B00093, 32'h0, 4'h0); step();
      chk("t2_err", longint'(o_err), 1);
      chk("t2_idx", longint'(o_err_idx), 1);
      chk("t2_count", longint'(o_check_count), 2);
      #2 reset = 1'b1;
      #1;
      chk("async_err", longint'(o_err), 0);
      chk("async_learned", longint'(o_learned), 0);
      chk("async_count", longint'(o_check_count), 0);

      do_reset(32'h202, 32'h400, 32'h400, 32'h400);
      drive(0, 32'h200, 32'h00004501, 32'h0, 4'h0); step();
      chk("t3_nohit", longint'(o_learned), 0);
      drive(0, 32'h202, 32'h0000C0DE, 32'h0, 4'h0); step();
      chk("t3_learn", longint'(o_learned), 1);

      do_reset(32'h100, 32'h400, 32'h400, 32'h400);
      drive(0, 32'h100, 32'h00000093, 32'h0, 4'h0);
      drive(1, 32'h100, 32'h00000013, 32'h0, 4'h0); step();
      chk("t4_err", longint'(o_err), 1);
      chk("t4_idx", longint'(o_err_idx), 0);
      chk("t4_count", longint'(o_check_count), 1);

      do_reset(32'h100, 32'h400, 32'h400, 32'h400);
      drive(0, 32'h100, 32'h00A00093, 32'h0, 4'h0); step();
      chk("t5_learn", longint'(o_learned), 1);
      drive(0, 32'h500, 32'h00000013, 32'h100, 4'b0010); step();
      chk("t5_inval", longint'(o_learned), 0);
      drive(0, 32'h100, 32'h00B00013, 32'h0, 4'h0); step();
      chk("t5_relearn", longint'(o_learned), 1);
      chk("t5_noerr", longint'(o_err), 0);
      chk("t5_count", longint'(o_check_count), 0);

      do_reset(32'h0, 32'h400, 32'h400, 32'h400);
      drive(0, 32'hFFFF_FFFE, 32'h12340003, 32'h0, 4'h0); step();
      chk("wrap_learn", longint'(o_learned), 1);
      drive(0, 32'h0, 32'h00001235, 32'h0, 4'h0); step();
      chk("wrap_err", longint'(o_err), 1);
      chk("wrap_count", longint'(o_check_count), 1);

      do_reset(32'h101, 32'h400, 32'h400, 32'h400);
      drive(0, 32'h101, 32'h00000013, 32'h0, 4'h0); step();
      chk("odd_pc", longint'(o_learned), 0);
      drive(0, 32'h100, 32'h00000013, 32'h0, 4'h0); step();
      chk("odd_trk", longint'(o_learned), 1);

      do_reset(32'h100, 32'h100, 32'h100, 32'h100);
      for (int n = 0; n < 10; n++) begin
         drive(0, 32'h100, 32'h00000013, 32'h0, 4'h0);
         drive(1, 32'h100, 32'h00000013, 32'h0, 4'h0);
         step();
         if (n == 0) chk("sat_first", longint'(o_check_count), 4);
      end
      chk("sat_count", longint'(o_check_count), CMAX);
      chk("sat_err", longint'(o_err), 0);

      for (int seg = 0; seg < 30; seg++) begin
         do_reset(apool[$urandom_range(0, 5)], apool[$urandom_range(0, 5)],
                  apool[$urandom_range(0, 5)], apool[$urandom_range(0, 5)]);
         for (int n = 0; n < 120; n++) begin
            for (int c = 0; c < NRET; c++) begin
               if ($urandom_range(0, 3) != 0) begin
                  p  = ppool[$urandom_range(0, 6)];
                  lo = memh(p);
                  hi = memh(p + 32'd2);
                  if ($urandom_range(0, 40) == 0) lo = lo ^ 16'h0100;
                  if ($urandom_range(0, 40) == 0) hi = hi ^ 16'h0010;
                  drive(c, p, {hi, lo}, spool[$urandom_range(0, 3)],
                        ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
               end
            end
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
